min_pooling_div_62ns_32s_64_seq: RTL and testbench

MIN_POOLING_DIV_62NS_32S_64_SEQ -- requirements
Module: min_pooling_div_62ns_32s_64_seq

---
 rtl/min_pooling_div_62ns_32s_64_seq.sv | 124 ++++++++++++
 tb/tb_min_pooling_div_62ns_32s_64_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/min_pooling_div_62ns_32s_64_seq.sv
// rtl/min_pooling_div_62ns_32s_64_seq.sv - sequential radix-2 restoring divider, unsigned dividend by signed divisor
module min_pooling_div_62ns_32s_64_seq #(
    parameter int DIVIDEND_WIDTH = 62,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int QUOTIENT_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      busy,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH);
    localparam logic [DIVISOR_WIDTH-1:0]  ONE_D = 1;
    localparam logic [QUOTIENT_WIDTH-1:0] ONE_Q = 1;
    localparam logic [CW-1:0]             ONE_C = 1;
    localparam logic [CW-1:0]             CNT_LOAD = CW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                    state, state_next;
    logic [CW-1:0]             cnt;
    // Holds the dividend; quotient bits shift in from the LSB, so after the
    // last step it contains the quotient magnitude.
    logic [DIVIDEND_WIDTH-1:0] dividend_r;
    logic [DIVISOR_WIDTH-1:0]  divisor_r;
    logic [DIVISOR_WIDTH:0]    part_r;
    logic                      neg_r;
    logic                      zero_r;

    logic                      accept;
    logic [DIVISOR_WIDTH-1:0]  din1_mag;
    logic [DIVISOR_WIDTH:0]    shifted;
    logic [DIVISOR_WIDTH:0]    diff;
    logic                      q_bit;
    logic [QUOTIENT_WIDTH-1:0] q_ext;
    logic [QUOTIENT_WIDTH-1:0] quot_val;

    // A start coinciding with the done pulse is not accepted.
    assign accept   = ce && (state == IDLE) && start && !done;
    // Two's complement magnitude; -2^(W-1) maps to 2^(W-1) as unsigned.
    assign din1_mag = din1[DIVISOR_WIDTH-1] ? ((~din1) + ONE_D) : din1;
    assign shifted  = {part_r[DIVISOR_WIDTH-1:0], dividend_r[DIVIDEND_WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor_r};
    assign q_bit    = (shifted >= {1'b0, divisor_r});
    assign q_ext    = {{(QUOTIENT_WIDTH-DIVIDEND_WIDTH){1'b0}}, dividend_r};
    assign quot_val = neg_r ? ((~q_ext) + ONE_Q) : q_ext;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; nothing advances while ce is low.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (ce && cnt == '0) state_next = FIN;
            FIN:     if (ce) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, one restoring step per enabled CALC cycle, result write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            dividend_r  <= '0;
            divisor_r   <= '0;
            part_r      <= '0;
            neg_r       <= 1'b0;
            zero_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_r  <= din0;
                        divisor_r   <= din1_mag;
                        neg_r       <= din1[DIVISOR_WIDTH-1];
                        zero_r      <= (din1 == '0);
                        part_r      <= '0;
                        cnt         <= CNT_LOAD;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    part_r     <= q_bit ? diff : shifted;
                    dividend_r <= {dividend_r[DIVIDEND_WIDTH-2:0], q_bit};
                    cnt        <= cnt - ONE_C;
                end
                FIN: begin
                    // With a zero divisor every step subtracts nothing, so the
                    // partial remainder ends up as the low dividend bits.
                    quot        <= zero_r ? '1 : quot_val;
                    rem         <= part_r[DIVISOR_WIDTH-1:0];
                    div_by_zero <= zero_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_min_pooling_div_62ns_32s_64_seq.sv
// tb/tb_min_pooling_div_62ns_32s_64_seq.sv - scoreboard bench for the sequential divider
module tb_min_pooling_div_62ns_32s_64_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [61:0] din0;
    logic [31:0] din1;
    logic        busy;
    logic        done;
    logic [63:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    typedef struct {
        logic [63:0] quot;
        logic [31:0] rem;
        logic        dbz;
    } result_t;

    result_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    min_pooling_div_62ns_32s_64_seq dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic result_t model(input logic [61:0] a, input logic [31:0] b);
        result_t r;
        logic [63:0] mag;
        logic [63:0] q;
        mag = {32'd0, (b[31] ? (32'd0 - b) : b)};
        if (b == 32'd0) begin
            r.quot = '1;
            r.rem  = a[31:0];
            r.dbz  = 1'b1;
        end else begin
            q      = {2'b00, a} / mag;
            r.quot = b[31] ? (64'd0 - q) : q;
            r.rem  = 32'(({2'b00, a} % mag));
            r.dbz  = 1'b0;
        end
        return r;
    endfunction

    // Runs one division; optional ce-low window and a start re-pulse while busy.
    task automatic do_div(input string tag, input logic [61:0] a, input logic [31:0] b,
                          input int low_at, input int low_len, input int restart_at);
        result_t e;
        int n;
        bit seen;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b1; ce = 1'b1; din0 = a; din1 = b;
        @(posedge clk); #1;
        check({tag, "_busy_set"}, {63'd0, busy}, 64'd1);
        n = 0;
        seen = 0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            ce = (n >= low_at && n < low_at + low_len) ? 1'b0 : 1'b1;
            if (n == restart_at) begin
                start = 1'b1;
                din0  = 62'd5;
                din1  = 32'd1;
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(63 + low_len));
        e = exp_q.pop_front();
        check({tag, "_quot"}, quot, e.quot);
        check({tag, "_rem"}, {32'd0, rem}, {32'd0, e.rem});
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
        check({tag, "_busy_clr"}, {63'd0, busy}, 64'd0);
        // A start during the done cycle must be ignored.
        @(negedge clk);
        start = 1'b1; ce = 1'b1; din0 = 62'd9; din1 = 32'd2;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_start_on_done"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit saw_done;
        reset = 1'b1; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_quot", quot, 64'd0);
        check("rst_rem", {32'd0, rem}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0; ce = 1'b1;

        do_div("d100_7", 62'd100, 32'd7, 1000, 0, 1000);
        check("d100_7_known", quot, 64'd14);
        do_div("d100_m7", 62'd100, 32'hFFFF_FFF9, 1000, 0, 1000);
        check("d100_m7_known", quot, 64'hFFFF_FFFF_FFFF_FFF2);
        do_div("dmax_1", 62'h3FFF_FFFF_FFFF_FFFF, 32'd1, 1000, 0, 1000);
        do_div("d2p40_min", 62'd1 << 40, 32'h8000_0000, 1000, 0, 1000);
        check("d2p40_min_known", quot, 64'hFFFF_FFFF_FFFF_FE00);
        do_div("dzero", 62'h1_2345_6789, 32'd0, 1000, 0, 1000);
        check("dzero_known_rem", {32'd0, rem}, 64'h2345_6789);
        do_div("after_zero", 62'd1000, 32'd3, 1000, 0, 1000);
        do_div("ce_gap", 62'h2AB_CDEF_0123, 32'd12345, 20, 10, 35);
        for (int i = 0; i < 3; i++) begin
            logic [61:0] ra;
            logic [31:0] rb;
            ra = {$urandom, $urandom};
            rb = $urandom;
            do_div("rand", ra, rb, 1000, 0, 1000);
        end

        // Abort an in-flight division with reset at CALC step 30.
        @(negedge clk);
        start = 1'b1; din0 = 62'd777; din1 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_quot", quot, 64'd0);
        check("abort_rem", {32'd0, rem}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        n = 0;
        while (n < 80) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
            n++;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        do_div("post_abort", 62'd777, 32'd5, 1000, 0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
